// File: rtl/clock_time_ctrl_if.sv
// Handshake bundle between the timekeeping controller and its divider/button/display neighbours.
// master drives strobes and buttons and watches the time; slave is the controller.
interface clock_time_ctrl_if;
   logic       ms_tick;
   logic       btn_mode;
   logic       btn_inc;
   logic [7:0] hours;
   logic [7:0] minutes;
   logic [7:0] seconds;
   logic [2:0] mode;
   logic       sec_pulse;
   logic       blink;
   logic       alarm;

   modport master (
      output ms_tick, btn_mode, btn_inc,
      input  hours, minutes, seconds, mode, sec_pulse, blink, alarm
   );

   modport slave (
      input  ms_tick, btn_mode, btn_inc,
      output hours, minutes, seconds, mode, sec_pulse, blink, alarm
   );
endinterface

// File: rtl/clock_time_ctrl.sv
// BCD HH:MM:SS timekeeping and set-mode FSM; every output registered, one cycle after its cause, no backpressure.
// Optional alarm (extra SET_ALM_H/SET_ALM_M states, alarm output) is built when CLOCK_ALARM_EN is defined.
module clock_time_ctrl #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int SUB_W         = 10
) (
   input  logic             clk,
   input  logic             rst,
   clock_time_ctrl_if.slave ctrl_if
);
   typedef enum logic [2:0] {
      RUN       = 3'b000,
      SET_HOUR  = 3'b001,
      SET_MIN   = 3'b010,
      SET_ALM_H = 3'b011,
      SET_ALM_M = 3'b100
   } mode_e;

   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
   localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(TICKS_PER_SEC / 2);

   mode_e            mode_q, mode_d;
   logic [SUB_W-1:0] sub_q, sub_d, sub_wrap;
   logic [7:0]       hr_q, hr_d, min_q, min_d, sec_q, sec_d;
   logic             pulse_q, pulse_d, blink_q, blink_d;
   logic             sec_roll;
`ifdef CLOCK_ALARM_EN
   logic [7:0]       alm_h_q, alm_h_d, alm_m_q, alm_m_d;
   logic [7:0]       disp_h_q, disp_m_q;
   logic             alarm_q, alarm_d;
   logic             show_alm;
`endif

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max) return 8'h00;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic mode_e next_set(input mode_e m);
      case (m)
         SET_HOUR:  return SET_MIN;
`ifdef CLOCK_ALARM_EN
         SET_MIN:   return SET_ALM_H;
         SET_ALM_H: return SET_ALM_M;
`endif
         default:   return RUN;
      endcase
   endfunction

   assign sub_wrap = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
   // A mode press in RUN swallows a coincident tick.
   assign sec_roll = (mode_q == RUN) && !ctrl_if.btn_mode && ctrl_if.ms_tick && (sub_q == SUB_LAST);

   always_comb begin
      mode_d  = mode_q;
      sub_d   = sub_q;
      hr_d    = hr_q;
      min_d   = min_q;
      sec_d   = sec_q;
      pulse_d = 1'b0;
      blink_d = blink_q;
`ifdef CLOCK_ALARM_EN
      alm_h_d = alm_h_q;
      alm_m_d = alm_m_q;
      alarm_d = alarm_q;
`endif
      case (mode_q)
         RUN: begin
            blink_d = 1'b0;
            if (ctrl_if.btn_mode) begin
               mode_d  = SET_HOUR;
               sub_d   = '0;
               blink_d = 1'b1;
`ifdef CLOCK_ALARM_EN
               alarm_d = 1'b0;
`endif
            end else begin
               if (ctrl_if.ms_tick) sub_d = sub_wrap;
               if (sec_roll) begin
                  pulse_d = 1'b1;
                  sec_d   = bcd_inc(sec_q, 8'h59);
                  if (sec_q == 8'h59) begin
                     min_d = bcd_inc(min_q, 8'h59);
                     if (min_q == 8'h59) hr_d = bcd_inc(hr_q, 8'h23);
                  end
               end
`ifdef CLOCK_ALARM_EN
               if (sec_roll && sec_q == 8'h59 && hr_d == alm_h_q && min_d == alm_m_q)
                  alarm_d = 1'b1;
               else if (ctrl_if.btn_inc ||
                        (sec_roll && sec_q == 8'h59 && hr_q == alm_h_q && min_q == alm_m_q))
                  alarm_d = 1'b0;
`endif
            end
         end
         default: begin
            if (ctrl_if.btn_mode) begin
               sub_d  = '0;
               mode_d = next_set(mode_q);
               if (mode_d == RUN) begin
                  sec_d   = 8'h00;
                  blink_d = 1'b0;
               end else begin
                  blink_d = 1'b1;
               end
            end else if (ctrl_if.btn_inc) begin
               // Restart the blink phase so the edited digits stay lit.
               sub_d   = '0;
               blink_d = 1'b1;
               case (mode_q)
                  SET_HOUR:  hr_d    = bcd_inc(hr_q, 8'h23);
                  SET_MIN:   min_d   = bcd_inc(min_q, 8'h59);
`ifdef CLOCK_ALARM_EN
                  SET_ALM_H: alm_h_d = bcd_inc(alm_h_q, 8'h23);
                  SET_ALM_M: alm_m_d = bcd_inc(alm_m_q, 8'h59);
`endif
                  default: ;
               endcase
            end else if (ctrl_if.ms_tick) begin
               sub_d   = sub_wrap;
               blink_d = (sub_wrap < SUB_HALF);
            end
         end
      endcase
   end

`ifdef CLOCK_ALARM_EN
   assign show_alm = (mode_d == SET_ALM_H) || (mode_d == SET_ALM_M);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= RUN;
         sub_q    <= '0;
         hr_q     <= 8'h00;
         min_q    <= 8'h00;
         sec_q    <= 8'h00;
         pulse_q  <= 1'b0;
         blink_q  <= 1'b0;
`ifdef CLOCK_ALARM_EN
         alm_h_q  <= 8'h00;
         alm_m_q  <= 8'h00;
         disp_h_q <= 8'h00;
         disp_m_q <= 8'h00;
         alarm_q  <= 1'b0;
`endif
      end else begin
         mode_q   <= mode_d;
         sub_q    <= sub_d;
         hr_q     <= hr_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
         pulse_q  <= pulse_d;
         blink_q  <= blink_d;
`ifdef CLOCK_ALARM_EN
         alm_h_q  <= alm_h_d;
         alm_m_q  <= alm_m_d;
         disp_h_q <= show_alm ? alm_h_d : hr_d;
         disp_m_q <= show_alm ? alm_m_d : min_d;
         alarm_q  <= alarm_d;
`endif
      end
   end

   assign ctrl_if.seconds   = sec_q;
   assign ctrl_if.mode      = mode_q;
   assign ctrl_if.sec_pulse = pulse_q;
   assign ctrl_if.blink     = blink_q;
`ifdef CLOCK_ALARM_EN
   assign ctrl_if.hours     = disp_h_q;
   assign ctrl_if.minutes   = disp_m_q;
   assign ctrl_if.alarm     = alarm_q;
`else
   assign ctrl_if.hours     = hr_q;
   assign ctrl_if.minutes   = min_q;
   assign ctrl_if.alarm     = 1'b0;
`endif
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: seconds-of-day reference model checked every cycle, plus directed literal checks.
module tb_clock_time_ctrl;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   tick_en = 1'b0;
   bit   chk_en  = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   clock_time_ctrl_if bus();

   clock_time_ctrl #(.TICKS_PER_SEC(T), .SUB_W(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .ctrl_if (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      check(name, {24'h0, act}, {24'h0, exp});
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
   endtask

   // Reference model: time held as seconds-of-day, alarm as minutes-of-day.
   int m_tod, m_sub, m_mode, m_alm;
   bit m_pulse, m_blink, m_alarm;
`ifdef CLOCK_ALARM_EN
   bit m_rolled;
`endif

   function automatic int next_mode(input int md);
`ifdef CLOCK_ALARM_EN
      return (md == 4) ? 0 : md + 1;
`else
      return (md == 2) ? 0 : md + 1;
`endif
   endfunction

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_tod = 0; m_sub = 0; m_mode = 0; m_alm = 0;
         m_pulse = 0; m_blink = 0; m_alarm = 0;
      end else if (m_mode == 0) begin
         m_pulse = 0;
         m_blink = 0;
         if (bus.btn_mode) begin
            m_mode = 1; m_sub = 0; m_blink = 1; m_alarm = 0;
         end else begin
`ifdef CLOCK_ALARM_EN
            m_rolled = 0;
`endif
            if (bus.ms_tick) begin
               if (m_sub == T - 1) begin
                  m_sub = 0;
                  m_tod = (m_tod + 1) % 86400;
                  m_pulse = 1;
`ifdef CLOCK_ALARM_EN
                  m_rolled = (m_tod % 60 == 0);
`endif
               end else begin
                  m_sub++;
               end
            end
`ifdef CLOCK_ALARM_EN
            if (m_rolled && m_tod / 60 == m_alm) m_alarm = 1;
            else if (bus.btn_inc || (m_rolled && (m_tod / 60 + 1439) % 1440 == m_alm)) m_alarm = 0;
`endif
         end
      end else begin
         m_pulse = 0;
         if (bus.btn_mode) begin
            m_sub = 0;
            m_mode = next_mode(m_mode);
            if (m_mode == 0) begin
               m_tod = m_tod - m_tod % 60;
               m_blink = 0;
            end else begin
               m_blink = 1;
            end
         end else if (bus.btn_inc) begin
            m_sub = 0;
            m_blink = 1;
            case (m_mode)
               1: m_tod = ((m_tod / 3600 + 1) % 24) * 3600 + m_tod % 3600;
               2: m_tod = (m_tod / 3600) * 3600 + (((m_tod / 60) % 60 + 1) % 60) * 60 + m_tod % 60;
               3: m_alm = ((m_alm / 60 + 1) % 24) * 60 + m_alm % 60;
               4: m_alm = (m_alm / 60) * 60 + (m_alm % 60 + 1) % 60;
               default: ;
            endcase
         end else if (bus.ms_tick) begin
            m_sub = (m_sub + 1) % T;
            m_blink = (m_sub < T / 2);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int dh, dm;
         dh = (m_mode >= 3) ? m_alm / 60 : m_tod / 3600;
         dm = (m_mode >= 3) ? m_alm % 60 : (m_tod / 60) % 60;
         check("cycle {h,m,s,mode,pulse,blink,alarm}",
               {2'b0, bus.hours, bus.minutes, bus.seconds, bus.mode, bus.sec_pulse, bus.blink, bus.alarm},
               {2'b0, bcd(dh), bcd(dm), bcd(m_tod % 60), 3'(m_mode), m_pulse, m_blink, m_alarm});
      end
   end

   // ms_tick generator: one strobe every third clock while enabled.
   initial begin
      int cnt;
      cnt = 0;
      bus.ms_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_en && cnt == 2) begin
            bus.ms_tick = 1'b1;
            cnt = 0;
         end else begin
            bus.ms_tick = 1'b0;
            if (tick_en) cnt++;
         end
      end
   end

   task automatic press(input logic m, input logic i);
      @(posedge clk); #2;
      bus.btn_mode = m;
      bus.btn_inc  = i;
      @(posedge clk); #2;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
   endtask

   task automatic press_n(input logic m, input logic i, input int n);
      for (int k = 0; k < n; k++) press(m, i);
   endtask

   task automatic wait_pulse(input string name, input int budget);
      bit ok;
      ok = 0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk); #2;
         if (bus.sec_pulse) begin ok = 1; break; end
      end
      if (!ok) timeout(name);
   endtask

   initial begin
      int n;
      bit ok;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;

      // Reset for two cycles.
      repeat (2) @(posedge clk);
      #2;
      chk_en = 1'b1;
      chk8("rst hours", bus.hours, 8'h00);
      chk8("rst minutes", bus.minutes, 8'h00);
      chk8("rst seconds", bus.seconds, 8'h00);
      chk8("rst mode", 8'(bus.mode), 8'h00);
      chk8("rst pulse/blink/alarm", {5'b0, bus.sec_pulse, bus.blink, bus.alarm}, 8'h00);
      rst = 1'b0;
      tick_en = 1'b1;

      // First second after four ticks.
      wait_pulse("first sec_pulse", 40);
      chk8("first second", bus.seconds, 8'h01);
      @(posedge clk); #2;
      chk8("sec_pulse one cycle", 8'(bus.sec_pulse), 8'h00);

      // Preload 23:59 through set mode.
      press(1, 0);
      chk8("enter SET_HOUR", 8'(bus.mode), 8'h01);
      chk8("blink on entry", 8'(bus.blink), 8'h01);
      press_n(0, 1, 23);
      chk8("hours preload", bus.hours, 8'h23);
      press(1, 0);
      press_n(0, 1, 59);
      chk8("minutes preload", bus.minutes, 8'h59);
`ifdef CLOCK_ALARM_EN
      press_n(1, 0, 3);
`else
      press(1, 0);
`endif
      chk8("exit mode", 8'(bus.mode), 8'h00);
      chk8("exit seconds", bus.seconds, 8'h00);
      for (int k = 0; k < 59; k++) wait_pulse("run 59 s", 20);
      check("23:59:59", {8'h0, bus.hours, bus.minutes, bus.seconds}, 32'h0023_5959);
      wait_pulse("midnight", 20);
      check("midnight rollover", {8'h0, bus.hours, bus.minutes, bus.seconds}, 32'h0000_0000);

      // Enter SET_HOUR on a cycle that also carries a tick.
      ok = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #2;
         if (bus.ms_tick) begin ok = 1; break; end
      end
      if (!ok) timeout("tick alignment");
      bus.btn_mode = 1'b1;
      @(posedge clk); #2;
      bus.btn_mode = 1'b0;
      chk8("mode beats tick", 8'(bus.mode), 8'h01);
      for (int k = 0; k < 25; k++) begin
         press(0, 1);
         chk8("blink after inc", 8'(bus.blink), 8'h01);
      end
      chk8("hours after 25 inc", bus.hours, 8'h01);
      chk8("minutes untouched", bus.minutes, 8'h00);

      // Mode and inc together: mode wins.
      press(1, 1);
      chk8("mode+inc mode", 8'(bus.mode), 8'h02);
      chk8("mode+inc hours", bus.hours, 8'h01);
`ifdef CLOCK_ALARM_EN
      press_n(1, 0, 3);
`else
      press(1, 0);
`endif
      chk8("back to RUN", 8'(bus.mode), 8'h00);
      chk8("RUN seconds", bus.seconds, 8'h00);
      n = 0;
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         if (bus.ms_tick) n++;
         #2;
         if (bus.sec_pulse) begin ok = 1; break; end
      end
      if (!ok) timeout("sub cleared on exit");
      chk8("ticks to first second", 8'(n), 8'd4);

      // Reset while editing 12:34.
      press(1, 0);
      press_n(0, 1, 11);
      press(1, 0);
      press_n(0, 1, 34);
      check("12:34 in SET_MIN", {13'h0, bus.mode, bus.hours, bus.minutes}, {13'h0, 3'd2, 8'h12, 8'h34});
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      check("mid-op reset", {5'h0, bus.mode, bus.hours, bus.minutes, bus.seconds},
            {5'h0, 3'd0, 8'h00, 8'h00, 8'h00});
      chk8("mid-op reset blink", 8'(bus.blink), 8'h00);
      rst = 1'b0;

`ifdef CLOCK_ALARM_EN
      // Alarm at 00:01 fires on the minute and is acknowledged by inc.
      press_n(1, 0, 3);
      chk8("SET_ALM_H mode", 8'(bus.mode), 8'h03);
      press(1, 0);
      press(0, 1);
      chk8("alarm minute shown", bus.minutes, 8'h01);
      press(1, 0);
      ok = 0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk); #2;
         if (bus.alarm) begin ok = 1; break; end
      end
      if (!ok) timeout("alarm fire");
      check("alarm time", {8'h0, bus.hours, bus.minutes, bus.seconds}, 32'h0000_0100);
      press(0, 1);
      chk8("alarm ack", 8'(bus.alarm), 8'h00);
`endif

      repeat (5) @(posedge clk);
      #2;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
